// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared RV32I pipeline definitions used by the MEM/WB stage and its helpers:
//   - write-back select encodings (WB_MEM / WB_ALU / WB_PC4)
//   - load funct3 encodings
//   - packed MEM/WB control bundle and its reset value
//   - helper that decides whether a load is misaligned for its byte offset
// -----------------------------------------------------------------------------
package riscv_pkg;

  // Write-back mux select encodings
  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Control bundle carried from MEM into WB
  typedef struct packed {
    logic [1:0] wb_sel;
    logic [2:0] funct3;
    logic [1:0] offset;
    logic       reg_write;
    logic       load_misaligned;
  } mem_wb_ctrl_t;

  // Reset/bubble-free idle value: ALU write-back, word load type, no write
  localparam mem_wb_ctrl_t CTRL_RESET = '{
    wb_sel:          WB_ALU,
    funct3:          F3_LW,
    offset:          2'b00,
    reg_write:       1'b0,
    load_misaligned: 1'b0
  };

  // Byte loads are never misaligned; halves need an even offset; every other
  // funct3 value is handled as a word load and needs offset 0.
  function automatic logic load_is_misaligned(input logic [2:0] funct3,
                                              input logic [1:0] offset);
    logic mis;
    case (funct3)
      F3_LB, F3_LBU: mis = 1'b0;
      F3_LH, F3_LHU: mis = offset[0];
      default:       mis = (offset != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_wb_stage_load_extend.sv
// -----------------------------------------------------------------------------
// load_extend
// Combinational load-data alignment: picks the addressed byte/half/word out of
// a 32-bit memory word and sign- or zero-extends it according to funct3.
// A misaligned access yields zero.
// Ports:
//   rdata_i      [31:0] raw word from the data memory
//   offset_i     [1:0]  byte offset of the access inside the word
//   funct3_i     [2:0]  load type (LB/LH/LW/LBU/LHU, others treated as LW)
//   misaligned_i        access was flagged as misaligned
//   data_o       [31:0] aligned, extended load result
// -----------------------------------------------------------------------------
module load_extend
  import riscv_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  input  logic        misaligned_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection: byte by full offset, half by offset[1] only
  always_comb begin
    byte_s = rdata_i[{offset_i, 3'b000} +: 8];
    half_s = rdata_i[{offset_i[1], 4'b0000} +: 16];
  end

  // Extension per load type; misaligned accesses produce zero
  always_comb begin
    data_o = 32'h0000_0000;
    if (misaligned_i) begin
      data_o = 32'h0000_0000;
    end else begin
      case (funct3_i)
        F3_LB:   data_o = {{24{byte_s[7]}}, byte_s};
        F3_LBU:  data_o = {24'h00_0000, byte_s};
        F3_LH:   data_o = {{16{half_s[15]}}, half_s};
        F3_LHU:  data_o = {16'h0000, half_s};
        default: data_o = rdata_i;
      endcase
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
// MEM/WB pipeline register for the RV32I pipeline plus load-data alignment.
// Captures the MEM-stage results on the rising clock edge, drives the data
// memory read enable, and aligns/extends the synchronous read word in WB.
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   stall, flush        hold the WB registers / insert a bubble
//   ALU_out_m           ALU result, also the data-memory byte address
//   PC_adder_out_m      PC+4 of the MEM-stage instruction
//   WB_Sel_m            00 load, 01 ALU, 10 PC+4
//   funct3_m            load type
//   rd_m, reg_write_m   destination register and its write enable
//   dmem_rd_en          data-memory read enable (combinational)
//   dmem_rdata          data-memory word, valid one cycle after the address
//   ALU_out_w, PC_adder_out_w, WB_Sel_w, rd_w   registered MEM values
//   DMem_out_w          aligned/extended load data
//   reg_write_w         registered write enable, cleared on misaligned loads
//   load_misaligned_w   registered misaligned-load flag
// -----------------------------------------------------------------------------
module mem_wb_stage
  import riscv_pkg::*;
#(
  parameter int size       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [size-1:0]       ALU_out_m,
  input  logic [size-1:0]       PC_adder_out_m,
  input  logic [1:0]            WB_Sel_m,
  input  logic [2:0]            funct3_m,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic                  reg_write_m,
  output logic                  dmem_rd_en,
  input  logic [size-1:0]       dmem_rdata,
  output logic [size-1:0]       ALU_out_w,
  output logic [size-1:0]       PC_adder_out_w,
  output logic [size-1:0]       DMem_out_w,
  output logic [1:0]            WB_Sel_w,
  output logic [REG_ADDR_W-1:0] rd_w,
  output logic                  reg_write_w,
  output logic                  load_misaligned_w
);

  logic [size-1:0]       alu_q, alu_d;
  logic [size-1:0]       pc4_q, pc4_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  mem_wb_ctrl_t          ctrl_q, ctrl_d;

  logic                  is_load_m_s;
  logic                  misaligned_m_s;
  mem_wb_ctrl_t          ctrl_m_s;

  // MEM-stage decode: misalignment only matters for loads
  always_comb begin
    is_load_m_s    = (WB_Sel_m == WB_MEM);
    misaligned_m_s = 1'b0;
    if (is_load_m_s) begin
      misaligned_m_s = load_is_misaligned(funct3_m, ALU_out_m[1:0]);
    end else begin
      misaligned_m_s = 1'b0;
    end
    ctrl_m_s.wb_sel          = WB_Sel_m;
    ctrl_m_s.funct3          = funct3_m;
    ctrl_m_s.offset          = ALU_out_m[1:0];
    ctrl_m_s.reg_write       = reg_write_m & ~misaligned_m_s;
    ctrl_m_s.load_misaligned = misaligned_m_s;
  end

  // Read enable is gated by rst so no access is issued for a discarded slot
  always_comb begin
    dmem_rd_en = is_load_m_s & ~stall & ~rst;
  end

  // Next-state selection: flush beats stall beats normal capture
  always_comb begin
    alu_d  = alu_q;
    pc4_d  = pc4_q;
    rd_d   = rd_q;
    ctrl_d = ctrl_q;
    if (flush) begin
      // Data registers follow MEM; only the control that commits is forced
      alu_d                  = ALU_out_m;
      pc4_d                  = PC_adder_out_m;
      rd_d                   = {REG_ADDR_W{1'b0}};
      ctrl_d                 = ctrl_m_s;
      ctrl_d.wb_sel          = WB_ALU;
      ctrl_d.reg_write       = 1'b0;
      ctrl_d.load_misaligned = 1'b0;
    end else if (stall) begin
      alu_d  = alu_q;
      pc4_d  = pc4_q;
      rd_d   = rd_q;
      ctrl_d = ctrl_q;
    end else begin
      alu_d  = ALU_out_m;
      pc4_d  = PC_adder_out_m;
      rd_d   = rd_m;
      ctrl_d = ctrl_m_s;
    end
  end

  // WB-stage registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_q  <= {size{1'b0}};
      pc4_q  <= {size{1'b0}};
      rd_q   <= {REG_ADDR_W{1'b0}};
      ctrl_q <= CTRL_RESET;
    end else begin
      alu_q  <= alu_d;
      pc4_q  <= pc4_d;
      rd_q   <= rd_d;
      ctrl_q <= ctrl_d;
    end
  end

  // Registered outputs
  always_comb begin
    ALU_out_w         = alu_q;
    PC_adder_out_w    = pc4_q;
    WB_Sel_w          = ctrl_q.wb_sel;
    rd_w              = rd_q;
    reg_write_w       = ctrl_q.reg_write;
    load_misaligned_w = ctrl_q.load_misaligned;
  end

  load_extend u_load_extend (
    .rdata_i      (dmem_rdata),
    .offset_i     (ctrl_q.offset),
    .funct3_i     (ctrl_q.funct3),
    .misaligned_i (ctrl_q.load_misaligned),
    .data_o       (DMem_out_w)
  );

endmodule

// File: tb/tb_mem_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_stage
// Self-checking bench for mem_wb_stage: reset and directed sequences, a table
// of load vectors, and a randomized run against a behavioural model.
// -----------------------------------------------------------------------------
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] ALU_out_m;
  logic [31:0] PC_adder_out_m;
  logic [1:0]  WB_Sel_m;
  logic [2:0]  funct3_m;
  logic [4:0]  rd_m;
  logic        reg_write_m;
  logic        dmem_rd_en;
  logic [31:0] dmem_rdata;
  logic [31:0] ALU_out_w;
  logic [31:0] PC_adder_out_w;
  logic [31:0] DMem_out_w;
  logic [1:0]  WB_Sel_w;
  logic [4:0]  rd_w;
  logic        reg_write_w;
  logic        load_misaligned_w;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.size(32), .REG_ADDR_W(5)) dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .flush             (flush),
    .ALU_out_m         (ALU_out_m),
    .PC_adder_out_m    (PC_adder_out_m),
    .WB_Sel_m          (WB_Sel_m),
    .funct3_m          (funct3_m),
    .rd_m              (rd_m),
    .reg_write_m       (reg_write_m),
    .dmem_rd_en        (dmem_rd_en),
    .dmem_rdata        (dmem_rdata),
    .ALU_out_w         (ALU_out_w),
    .PC_adder_out_w    (PC_adder_out_w),
    .DMem_out_w        (DMem_out_w),
    .WB_Sel_w          (WB_Sel_w),
    .rd_w              (rd_w),
    .reg_write_w       (reg_write_w),
    .load_misaligned_w (load_misaligned_w)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input logic [1:0] wbs, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] pc4, input logic [4:0] rd, input logic rw);
    WB_Sel_m       = wbs;
    funct3_m       = f3;
    ALU_out_m      = addr;
    PC_adder_out_m = pc4;
    rd_m           = rd;
    reg_write_m    = rw;
  endtask

  // ---------------- behavioural reference ----------------
  function automatic logic ref_misaligned(input logic [1:0] wbs, input logic [2:0] f3,
                                          input logic [31:0] addr);
    int off;
    off = int'(addr % 4);
    if (wbs != 2'd0) return 1'b0;
    if (f3 == 3'd0 || f3 == 3'd4) return 1'b0;
    if (f3 == 3'd1 || f3 == 3'd5) return (off % 2) != 0;
    return off != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input int off,
                                           input logic [2:0] f3, input logic mis);
    logic [31:0] b;
    logic [31:0] h;
    if (mis) return 32'd0;
    b = (word >> (8 * off)) & 32'h0000_00FF;
    h = (word >> (16 * (off / 2))) & 32'h0000_FFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'd5:    return h;
      default: return word;
    endcase
  endfunction

  typedef struct {
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [1:0]  wbs;
    logic [4:0]  rd;
    logic        rw;
    logic        mis;
    logic [2:0]  f3;
    int          off;
    logic        known;
  } wb_model_t;

  wb_model_t mdl;

  function automatic wb_model_t model_reset();
    wb_model_t m;
    m.alu = 32'd0; m.pc4 = 32'd0; m.wbs = 2'd1; m.rd = 5'd0;
    m.rw = 1'b0; m.mis = 1'b0; m.f3 = 3'd2; m.off = 0; m.known = 1'b1;
    return m;
  endfunction

  // ---------------- load vector table ----------------
  typedef struct {
    logic [1:0]  wbs;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] exp_dmem;
    logic        chk_dmem;
    logic        exp_mis;
    logic        exp_rw;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic        rd_en_prev;
    logic        exp_en;
    logic [31:0] mem_word;

    vecs[0]  = '{2'b00, 3'b000, 32'h0000_2000, 32'h80F1_7F82, 32'hFFFF_FF82, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{2'b00, 3'b100, 32'h0000_2001, 32'h80F1_7F82, 32'h0000_007F, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{2'b00, 3'b001, 32'h0000_2002, 32'h80F1_7F82, 32'hFFFF_80F1, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{2'b00, 3'b101, 32'h0000_2002, 32'h80F1_7F82, 32'h0000_80F1, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{2'b00, 3'b010, 32'h0000_2000, 32'h80F1_7F82, 32'h80F1_7F82, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{2'b00, 3'b010, 32'h0000_1002, 32'h80F1_7F82, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{2'b00, 3'b001, 32'h0000_2001, 32'h80F1_7F82, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{2'b00, 3'b000, 32'h0000_2003, 32'h80F1_7F82, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{2'b00, 3'b101, 32'h0000_2000, 32'h80F1_7F82, 32'h0000_7F82, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{2'b00, 3'b100, 32'h0000_2003, 32'h80F1_7F82, 32'h0000_0080, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{2'b00, 3'b011, 32'h0000_2000, 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{2'b00, 3'b111, 32'h0000_2002, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{2'b01, 3'b010, 32'h0000_1002, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{2'b00, 3'b001, 32'h0000_2003, 32'h7F00_8001, 32'h0000_0000, 1'b1, 1'b1, 1'b0};

    // ---------------- reset state ----------------
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    dmem_rdata = 32'hA5A5_0F0F;
    set_m(2'b00, 3'b010, 32'h0, 32'h0, 5'd0, 1'b0);
    tick();
    check("rst_reg_write", {31'd0, reg_write_w}, 32'd0);
    check("rst_wb_sel", {30'd0, WB_Sel_w}, 32'd1);
    check("rst_rd", {27'd0, rd_w}, 32'd0);
    check("rst_alu", ALU_out_w, 32'd0);
    check("rst_pc4", PC_adder_out_w, 32'd0);
    check("rst_mis", {31'd0, load_misaligned_w}, 32'd0);
    check("rst_rd_en", {31'd0, dmem_rd_en}, 32'd0);
    check("rst_dmem_word", DMem_out_w, 32'hA5A5_0F0F);
    rst = 1'b0;

    // ---------------- asynchronous reset mid-cycle ----------------
    set_m(2'b01, 3'b010, 32'h0000_0040, 32'h0000_0010, 5'd9, 1'b1);
    tick();
    check("pre_rst_reg_write", {31'd0, reg_write_w}, 32'd1);
    check("pre_rst_rd", {27'd0, rd_w}, 32'd9);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_reg_write", {31'd0, reg_write_w}, 32'd0);
    check("async_rst_wb_sel", {30'd0, WB_Sel_w}, 32'd1);
    check("async_rst_rd", {27'd0, rd_w}, 32'd0);
    rst = 1'b0;
    set_m(2'b01, 3'b010, 32'h0, 32'h0, 5'd0, 1'b0);
    tick();

    // ---------------- load vector table ----------------
    for (int i = 0; i < 14; i++) begin
      set_m(vecs[i].wbs, vecs[i].f3, vecs[i].addr, 32'h0000_0400 + i, 5'd12, 1'b1);
      #1;
      check($sformatf("v%0d_rd_en", i), {31'd0, dmem_rd_en}, {31'd0, vecs[i].wbs == 2'b00});
      tick();
      dmem_rdata = vecs[i].rdata;
      set_m(2'b01, 3'b010, 32'h0, 32'h0, 5'd0, 1'b0);
      #1;
      if (vecs[i].chk_dmem) check($sformatf("v%0d_dmem", i), DMem_out_w, vecs[i].exp_dmem);
      check($sformatf("v%0d_mis", i), {31'd0, load_misaligned_w}, {31'd0, vecs[i].exp_mis});
      check($sformatf("v%0d_reg_write", i), {31'd0, reg_write_w}, {31'd0, vecs[i].exp_rw});
      check($sformatf("v%0d_alu", i), ALU_out_w, vecs[i].addr);
    end

    // ---------------- misaligned then aligned LW ----------------
    set_m(2'b00, 3'b010, 32'h0000_1002, 32'h0, 5'd3, 1'b1);
    tick();
    dmem_rdata = 32'hDEAD_BEEF;
    set_m(2'b00, 3'b010, 32'h0000_1004, 32'h0, 5'd4, 1'b1);
    #1;
    check("mis_flag", {31'd0, load_misaligned_w}, 32'd1);
    check("mis_reg_write", {31'd0, reg_write_w}, 32'd0);
    check("mis_dmem", DMem_out_w, 32'd0);
    tick();
    dmem_rdata = 32'h1122_3344;
    set_m(2'b01, 3'b010, 32'h0, 32'h0, 5'd0, 1'b0);
    #1;
    check("aligned_clears_flag", {31'd0, load_misaligned_w}, 32'd0);
    check("aligned_reg_write", {31'd0, reg_write_w}, 32'd1);
    check("aligned_dmem", DMem_out_w, 32'h1122_3344);

    // ---------------- stall holds for 3 cycles ----------------
    set_m(2'b01, 3'b010, 32'h0000_1234, 32'h0000_0200, 5'd5, 1'b1);
    tick();
    check("stall_pre_rd", {27'd0, rd_w}, 32'd5);
    check("stall_pre_alu", ALU_out_w, 32'h0000_1234);
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1;
      set_m(2'b00, 3'b000, 32'h0000_2000 + 4 * i, 32'h0000_0300 + i, 5'd10 + 5'(i), 1'b1);
      #1;
      check($sformatf("stall%0d_rd_en", i), {31'd0, dmem_rd_en}, 32'd0);
      tick();
      check($sformatf("stall%0d_rd", i), {27'd0, rd_w}, 32'd5);
      check($sformatf("stall%0d_alu", i), ALU_out_w, 32'h0000_1234);
      check($sformatf("stall%0d_wb_sel", i), {30'd0, WB_Sel_w}, 32'd1);
      check($sformatf("stall%0d_reg_write", i), {31'd0, reg_write_w}, 32'd1);
    end
    stall = 1'b0;

    // ---------------- flush together with stall ----------------
    set_m(2'b00, 3'b010, 32'h0000_3000, 32'h0000_0500, 5'd7, 1'b1);
    stall = 1'b1; flush = 1'b1;
    tick();
    check("flush_reg_write", {31'd0, reg_write_w}, 32'd0);
    check("flush_rd", {27'd0, rd_w}, 32'd0);
    check("flush_wb_sel", {30'd0, WB_Sel_w}, 32'd1);
    check("flush_mis", {31'd0, load_misaligned_w}, 32'd0);
    stall = 1'b0; flush = 1'b0;

    // ---------------- JAL write-back ----------------
    set_m(2'b10, 3'b000, 32'h0000_0055, 32'h0000_0104, 5'd1, 1'b1);
    tick();
    check("jal_pc4", PC_adder_out_w, 32'h0000_0104);
    check("jal_wb_sel", {30'd0, WB_Sel_w}, 32'd2);
    check("jal_reg_write", {31'd0, reg_write_w}, 32'd1);
    check("jal_rd", {27'd0, rd_w}, 32'd1);

    // ---------------- randomized run against the model ----------------
    rst = 1'b1;
    #2;
    rst = 1'b0;
    mdl        = model_reset();
    mem_word   = 32'h0BAD_F00D;
    rd_en_prev = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (rd_en_prev) mem_word = $urandom;
      dmem_rdata = mem_word;
      set_m(2'($urandom_range(0, 2)), 3'($urandom_range(0, 7)), $urandom, $urandom,
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0);
      #1;
      exp_en = (WB_Sel_m == 2'd0) && !stall;
      check("rnd_rd_en", {31'd0, dmem_rd_en}, {31'd0, exp_en});
      if (mdl.known) check("rnd_dmem", DMem_out_w, ref_load(mem_word, mdl.off, mdl.f3, mdl.mis));
      rd_en_prev = exp_en;
      tick();
      if (flush) begin
        mdl.rw = 1'b0; mdl.mis = 1'b0; mdl.wbs = 2'd1; mdl.rd = 5'd0; mdl.known = 1'b0;
      end else if (!stall) begin
        mdl.alu   = ALU_out_m;
        mdl.pc4   = PC_adder_out_m;
        mdl.wbs   = WB_Sel_m;
        mdl.rd    = rd_m;
        mdl.f3    = funct3_m;
        mdl.off   = int'(ALU_out_m % 4);
        mdl.mis   = ref_misaligned(WB_Sel_m, funct3_m, ALU_out_m);
        mdl.rw    = reg_write_m && !mdl.mis;
        mdl.known = 1'b1;
      end
      check("rnd_rd", {27'd0, rd_w}, {27'd0, mdl.rd});
      check("rnd_reg_write", {31'd0, reg_write_w}, {31'd0, mdl.rw});
      check("rnd_wb_sel", {30'd0, WB_Sel_w}, {30'd0, mdl.wbs});
      check("rnd_mis", {31'd0, load_misaligned_w}, {31'd0, mdl.mis});
      if (mdl.known) begin
        check("rnd_alu", ALU_out_w, mdl.alu);
        check("rnd_pc4", PC_adder_out_w, mdl.pc4);
      end
    end
    stall = 1'b0; flush = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus load-data alignment for the RV32I pipeline.
- Captures MEM-stage results at the clock edge: ALU result, PC+4, write-back select, rd, reg-write.
- Drives the data-memory read enable.
- Sign- or zero-extends the synchronous data-memory read word according to the registered load type and byte offset.
- Its outputs feed the write-back select mux and the register file directly.

Parameters:
- size, 32, datapath width; only 32 is supported.
- REG_ADDR_W, 5, register-index width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold all WB-stage registers this cycle.
- flush  in  1  load a bubble into the WB stage this cycle.
- ALU_out_m  in  size  MEM-stage ALU result; also the data-memory byte address.
- PC_adder_out_m  in  size  MEM-stage PC+4.
- WB_Sel_m  in  2  00 = load, 01 = ALU, 10 = PC+4.
- funct3_m  in  3  load type (LB=000, LH=001, LW=010, LBU=100, LHU=101).
- rd_m  in  REG_ADDR_W  destination register.
- reg_write_m  in  1  MEM-stage write enable.
- dmem_rd_en  out  1  data-memory read enable.
- dmem_rdata  in  size  word read from the data memory, valid one cycle after the address.
- ALU_out_w  out  size  registered ALU result.
- PC_adder_out_w  out  size  registered PC+4.
- DMem_out_w  out  size  aligned and extended load data (combinational from registered state and dmem_rdata).
- WB_Sel_w  out  2  registered select.
- rd_w  out  REG_ADDR_W  registered destination.
- reg_write_w  out  1  registered write enable, qualified by fault.
- load_misaligned_w  out  1  registered misaligned-load flag.

Behaviour:
- Latency: one cycle, MEM to WB. The memory address is presented in MEM; dmem_rdata is consumed in WB.
- Reset (async, rst=1): all registered outputs are 0 except WB_Sel_w=01. Internal funct3_w=010 and offset_w=0. Reset mid-operation discards the in-flight instruction immediately, without waiting for a clock edge.
- dmem_rd_en = WB_Sel_m==00 && !stall && !rst.
  - Memory contract: dmem_rdata holds its last value while dmem_rd_en=0. This keeps the load result stable during a stall.
- Priority per clock edge: rst > flush > stall > normal capture.
- flush=1: reg_write_w=0, load_misaligned_w=0, WB_Sel_w=01, and rd_w=0. The other data registers may load any value. flush overrides a simultaneous stall.
- stall=1 (no flush): every register holds its value, and the outputs stay stable.
- Normal capture: all *_m inputs are registered into their *_w counterparts. offset_w = ALU_out_m[1:0] and funct3_w = funct3_m are also captured.
- Misalignment is computed in MEM and applies only when WB_Sel_m==00:
  - LH or LHU with offset[0]=1 is misaligned.
  - LW with offset != 0 is misaligned.
  - Any other funct3 value is treated as LW.
- Effect of a misaligned load:
  - load_misaligned_w=1 for that instruction.
  - reg_write_w=0.
  - DMem_out_w=0.
- Load extraction in WB:
  - Byte = dmem_rdata[8*offset_w +: 8].
  - Half = dmem_rdata[16*offset_w[1] +: 16].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word unchanged.
- When WB_Sel_w != 00, DMem_out_w is still computed, but the downstream mux ignores it.
- rd_w=0 with reg_write_w=1 is passed through unchanged; the register file ignores writes to x0.

Decomposition:
- Shared package (riscv_pkg):
  - WB_Sel encodings WB_MEM=2'b00, WB_ALU=2'b01, WB_PC4=2'b10.
  - Load funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - A packed struct for the MEM/WB control bundle.
- Sub-module load_extend: combinational. Inputs are rdata, offset, funct3 and misaligned; output is the extended data. It is instantiated once for the WB path and is reusable by a future store-forwarding path.

Test Plan:
- Reset: assert rst mid-cycle with reg_write_w=1 -> reg_write_w=0, WB_Sel_w=01, rd_w=0 immediately, before any clock edge.
- Loads, dmem_rdata=0x80F1_7F82 in the WB cycle:
  - LB at offset 0 -> DMem_out_w=0xFFFF_FF82.
  - LBU at offset 1 -> 0x0000_007F.
  - LH at offset 2 -> 0xFFFF_80F1.
  - LHU at offset 2 -> 0x0000_80F1.
  - LW at offset 0 -> 0x80F1_7F82.
- Misaligned: LW at address 0x1002 -> one cycle later load_misaligned_w=1, reg_write_w=0, DMem_out_w=0. A following aligned LW clears the flag.
- Stall: capture ALU op rd=5 with ALU_out=0x1234, then hold stall=1 for 3 cycles while the *_m inputs change -> outputs stay at rd_w=5, ALU_out_w=0x1234, and dmem_rd_en=0 throughout.
- Flush with stall: assert flush=1 and stall=1 together while a load to rd=7 is in MEM -> next cycle reg_write_w=0, rd_w=0, WB_Sel_w=01.
- JAL write-back: WB_Sel_m=10, PC_adder_out_m=0x0000_0104, rd=1 -> next cycle PC_adder_out_w=0x104, WB_Sel_w=10, reg_write_w=1.
